itof_sched: RTL and testbench
=============================

ITOF_SCHED -- requirements
Module: itof_sched

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of requester tag carried with each conversion.
REQ-002 SHALL have parameter NREQ, fixed at 2, number of requester ports.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  requester k offers an operand.
REQ-006 SHALL have port req_ready  output  2  requester k operand accepted this cycle when valid&ready.
REQ-007 SHALL have port req_data  input  2x32  signed 32-bit integer operand per requester.
REQ-008 SHALL have port req_tag  input  2xTAG_W  opaque tag per requester.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res_data  output  32  IEEE-754 single result.
REQ-012 SHALL have port res_tag  output  TAG_W  tag of originating operand.
REQ-013 SHALL have port res_src  output  1  index of originating requester.
REQ-014 SHALL have port inflight  output  2  count of operands accepted but not yet delivered (0..2).

Function
REQ-015 SHALL be a 2-stage pipeline: S1 holds accepted operand/tag/src; S2 holds converted result/tag/src; res_* driven from S2 only.
REQ-016 SHALL convert S1->S2 with the existing itof datapath: sign-magnitude, leading-one normalize, mantissa truncated (no rounding), 0 -> 0x00000000, 0x80000000 -> 0xCF000000.
REQ-017 SHALL give latency exactly 2 cycles from accept edge to res_valid with res_ready held high; throughput 1 result/cycle.
REQ-018 SHALL advance S2 when S2 empty or res_valid&res_ready; S1 moves to S2 when S1 full and S2 advances.
REQ-019 SHALL accept a new operand when S1 empty or S1 advancing this cycle; at most one requester accepted per cycle.
REQ-020 SHALL arbitrate round-robin: pointer last_grant; when both valid, grant the requester other than last_grant; single valid requester granted regardless of pointer.
REQ-021 SHALL update last_grant only on an accepted transfer, never on a stalled cycle.
REQ-022 SHALL drive req_ready combinationally from arbitration and pipeline space; req_ready[k] never asserted for both k in the same cycle.
REQ-023 SHALL, once res_valid asserts, hold res_data/res_tag/res_src stable until res_ready.
REQ-024 SHALL, with pipeline full and res_ready low, deassert both req_ready and retain all state (no loss, no duplication).
REQ-025 SHALL update inflight by +1 on accept, -1 on delivery, unchanged on simultaneous accept and delivery.
REQ-026 SHALL deliver results in acceptance order.

Reset
REQ-027 SHALL on rst assertion, asynchronously: S1/S2 empty, res_valid=0, req_ready=0 during reset, res_data=0, res_tag=0, res_src=0, inflight=0, last_grant=1 (requester 0 wins first contest).
REQ-028 SHALL discard in-flight operands on reset mid-operation; no result from pre-reset operands appears after reset release.
REQ-029 SHALL resume accepting on the first clock edge after rst deasserts.

Structure
REQ-030 SHALL place TAG_W default, NREQ, and a packed struct {data[31:0], tag, src} for pipeline stages in shared package fpu_pkg.
REQ-031 SHALL instantiate the existing itof module as its single sub-module between S1 and S2; no other arithmetic.

Verification
REQ-032 SHALL cover: req0 only, data 0x00000001 tag 3 -> 2 cycles later res_data 0x3F800000, res_tag 3, res_src 0.
REQ-033 SHALL cover: both requesters valid 4 cycles, data0 0xFFFFFFFF, data1 0x7FFFFFFF, res_ready=1 -> results alternate src 0,1,0,1 with 0xBF800000, 0x4EFFFFFF.
REQ-034 SHALL cover: req1 data 0x80000000 and 0x00000000 back-to-back -> 0xCF000000 then 0x00000000, inflight peaks at 2.
REQ-035 SHALL cover: res_ready low 5 cycles with both requesters valid -> exactly 2 accepted, req_ready=0 afterwards, res_* stable, no loss when released.
REQ-036 SHALL cover: rst pulsed while inflight=2 -> res_valid=0 immediately, inflight=0, no stale result after release.
REQ-037 SHALL cover: simultaneous accept and delivery each cycle in steady stream -> inflight constant at 2.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Shared constants and pipeline stage type for the integer-to-float
//   conversion scheduler and its datapath.
//   Contents:
//     TAG_W_DEF : default requester tag width
//     NREQ      : number of requester ports (the arbiter is written for 2)
//     stage_t   : payload held in each pipeline stage {data, tag, src}
package fpu_pkg;

  localparam int TAG_W_DEF = 4;
  localparam int NREQ      = 2;

  // The tag field is sized by the package default. Using a wider tag on the
  // scheduler means changing TAG_W_DEF here as well.
  typedef struct packed {
    logic [31:0]          data;
    logic [TAG_W_DEF-1:0] tag;
    logic                 src;
  } stage_t;

endpackage

// File: rtl/itof.sv
// itof
//   Combinational signed 32-bit integer to IEEE-754 single conversion.
//   Sign-magnitude form, leading-one normalisation, mantissa truncated
//   toward zero (no rounding). Zero maps to +0.0.
//   Ports:
//     i_int : signed 32-bit integer operand
//     o_flt : IEEE-754 single-precision result
module itof (
  input  logic [31:0] i_int,
  output logic [31:0] o_flt
);

  logic        w_sign;
  logic        w_zero;
  logic [31:0] w_mag;
  logic [4:0]  w_msb;
  logic [22:0] w_frac;
  logic [7:0]  w_exp;

  assign w_sign = i_int[31];
  assign w_zero = (i_int == 32'd0);

  // Two's-complement negate; 0x80000000 negates to itself, which read as
  // unsigned is exactly the 2^31 magnitude we want.
  assign w_mag = w_sign ? (~i_int + 32'd1) : i_int;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    w_msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) w_msb = 5'(i);
    end
  end

  // Shift the leading one up to bit 31; bits [30:8] are the kept fraction,
  // everything below is dropped (truncation).
  assign w_frac = 23'((w_mag << (5'd31 - w_msb)) >> 8);
  assign w_exp  = 8'd127 + {3'd0, w_msb};

  assign o_flt = w_zero ? 32'd0 : {w_sign, w_exp, w_frac};

endmodule

// File: rtl/itof_sched.sv
// itof_sched
//   Two-requester round-robin front end feeding a 2-stage int-to-float
//   pipeline. S1 holds the accepted operand, S2 the converted result; the
//   result port is driven only from S2.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     req_valid/req_ready   : per-requester handshake
//     req_data/req_tag      : per-requester signed operand and opaque tag
//     res_valid/res_ready   : result handshake
//     res_data/res_tag/src  : float result, originating tag and requester
//     inflight              : operands accepted but not yet delivered
module itof_sched #(
  parameter int TAG_W = fpu_pkg::TAG_W_DEF,
  parameter int NREQ  = fpu_pkg::NREQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][31:0]      req_data,
  input  logic [NREQ-1:0][TAG_W-1:0] req_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_src,
  output logic [1:0]                 inflight
);

  import fpu_pkg::*;

  stage_t      r_s1;
  stage_t      r_s2;
  logic        r_s1_v;
  logic        r_s2_v;
  logic        r_last_grant;
  logic [1:0]  r_inflight;

  logic        w_s2_adv;
  logic        w_s1_adv;
  logic        w_space;
  logic        w_deliver;
  logic        w_grant;
  logic        w_acc;
  logic [31:0] w_flt;
  stage_t      w_s1_in;
  stage_t      w_s2_in;

  // Pipeline flow control
  assign w_s2_adv  = !r_s2_v || res_ready;
  assign w_s1_adv  = r_s1_v && w_s2_adv;
  assign w_space   = !r_s1_v || w_s1_adv;
  assign w_deliver = r_s2_v && res_ready;

  // Round-robin: on contention the requester that did not win last time
  // gets the slot; a lone requester wins regardless of the pointer.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid[0] && req_valid[1]) begin
      w_grant = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_grant = 1'b1;
    end
  end

  // rst gates the ready path so nothing is offered while held in reset.
  assign w_acc = (|req_valid) && w_space && !rst;

  always_comb begin
    req_ready = '0;
    if (w_acc) req_ready[w_grant] = 1'b1;
  end

  assign w_s1_in = '{data: req_data[w_grant],
                     tag:  TAG_W_DEF'(req_tag[w_grant]),
                     src:  w_grant};

  itof u_itof (
    .i_int (r_s1.data),
    .o_flt (w_flt)
  );

  assign w_s2_in = '{data: w_flt, tag: r_s1.tag, src: r_s1.src};

  // S2: refills from S1 whenever it drains or is empty; its payload is only
  // rewritten when S1 has something, so a stalled result never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_s2   <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) r_s2 <= w_s2_in;
    end
  end

  // S1 and arbitration pointer; pointer moves only on an accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v       <= 1'b0;
      r_s1         <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_space) r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1         <= w_s1_in;
        r_last_grant <= w_grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 2'd0;
    end else begin
      case ({w_acc, w_deliver})
        2'b10:   r_inflight <= r_inflight + 2'd1;
        2'b01:   r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign res_valid = r_s2_v;
  assign res_data  = r_s2.data;
  assign res_tag   = TAG_W'(r_s2.tag);
  assign res_src   = r_s2.src;
  assign inflight  = r_inflight;

endmodule

// File: tb/tb_itof_sched.sv
module tb_itof_sched;

  localparam int TW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_data;
  logic [1:0][TW-1:0] req_tag;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_data;
  logic [TW-1:0]     res_tag;
  logic              res_src;
  logic [1:0]        inflight;

  always #5 clk = ~clk;

  itof_sched #(.TAG_W(TW), .NREQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .res_src   (res_src),
    .inflight  (inflight)
  );

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    logic [31:0]   exp;
  } vec_t;

  typedef struct {
    logic [31:0]   exp;
    logic [TW-1:0] tag;
    logic          src;
    int            acc_cyc;
  } sb_t;

  vec_t vq[2][$];
  sb_t  sb[$];
  int   src_log[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   res_cnt = 0;
  int   peak = 0;
  bit   lat_chk = 1'b0;

  bit            stall_prev = 1'b0;
  logic [31:0]   hold_data;
  logic [TW-1:0] hold_tag;
  logic          hold_src;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (vq[k].size() > 0) begin
        req_valid[k] = 1'b1;
        req_data[k]  = vq[k][0].data;
        req_tag[k]   = vq[k][0].tag;
      end else begin
        req_valid[k] = 1'b0;
        req_data[k]  = '0;
        req_tag[k]   = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push(input int k, input logic [31:0] d, input logic [TW-1:0] t, input logic [31:0] e);
    vec_t v;
    v.data = d;
    v.tag  = t;
    v.exp  = e;
    vq[k].push_back(v);
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (sb.size() == 0 && vq[0].size() == 0 && vq[1].size() == 0) break;
      tick();
    end
    if (i == budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: pending sb=%0d q0=%0d q1=%0d after %0d cycles",
               name, sb.size(), vq[0].size(), vq[1].size(), budget);
    end
  endtask

  int exp_src[4] = '{0, 1, 0, 1};
  int a0;
  int r0;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_tag   = '0;
    res_ready = 1'b0;

    fork
      begin : monitor
        vec_t v;
        sb_t  e;
        forever begin
          @(negedge clk);
          if (rst) begin
            stall_prev = 1'b0;
          end else begin
            check("ready_onehot", 32'(req_ready == 2'b11), 32'd0);
            for (int k = 0; k < 2; k++) begin
              if (req_valid[k] && req_ready[k] && vq[k].size() > 0) begin
                v = vq[k].pop_front();
                e.exp = v.exp;
                e.tag = v.tag;
                e.src = 1'(k);
                e.acc_cyc = cyc;
                sb.push_back(e);
                acc_cnt++;
              end
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            if (stall_prev) begin
              check("hold_valid", 32'(res_valid), 32'd1);
              check("hold_data", res_data, hold_data);
              check("hold_tag", 32'(res_tag), 32'(hold_tag));
              check("hold_src", 32'(res_src), 32'(hold_src));
            end
            if (res_valid && res_ready) begin
              if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got data 0x%08h tag %0d src %0d, expected none",
                         res_data, res_tag, res_src);
              end else begin
                e = sb.pop_front();
                check("res_data", res_data, e.exp);
                check("res_tag", 32'(res_tag), 32'(e.tag));
                check("res_src", 32'(res_src), 32'(e.src));
                if (lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
              end
              res_cnt++;
              src_log.push_back(int'(res_src));
            end
            stall_prev = res_valid && !res_ready;
            hold_data  = res_data;
            hold_tag   = res_tag;
            hold_src   = res_src;
          end
        end
      end
    join_none

    // Reset state, with both requesters already offering operands
    push(0, 32'hFFFF_FFFF, 4'd1, 32'hBF80_0000);
    push(0, 32'hFFFF_FFFF, 4'd2, 32'hBF80_0000);
    push(1, 32'h7FFF_FFFF, 4'd5, 32'h4EFF_FFFF);
    push(1, 32'h7FFF_FFFF, 4'd6, 32'h4EFF_FFFF);
    drive();
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    check("rst_res_src", 32'(res_src), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);

    // Contention from the first cycle after reset: requester 0 wins first
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    lat_chk   = 1'b1;
    drive();
    drain("contend", 40);
    check("contend_count", 32'(src_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (src_log.size() > i) check("contend_src_order", 32'(src_log[i]), 32'(exp_src[i]));
    end

    // Single requester 0, value 1
    src_log.delete();
    push(0, 32'h0000_0001, 4'd3, 32'h3F80_0000);
    drain("single", 20);
    check("single_count", 32'(src_log.size()), 32'd1);

    // Requester 1 back-to-back extremes; occupancy peaks at 2
    peak = 0;
    push(1, 32'h8000_0000, 4'd7, 32'hCF00_0000);
    push(1, 32'h0000_0000, 4'd8, 32'h0000_0000);
    drain("extremes", 20);
    check("extremes_peak", 32'(peak), 32'd2);

    // Output stall with both requesters pending
    res_ready = 1'b0;
    lat_chk   = 1'b0;
    a0 = acc_cnt;
    r0 = res_cnt;
    push(0, 32'h0000_0002, 4'd1, 32'h4000_0000);
    push(0, 32'hFFFF_FF00, 4'd2, 32'hC380_0000);
    push(0, 32'h0000_03E8, 4'd4, 32'h447A_0000);
    push(1, 32'h0000_0003, 4'd9, 32'h4040_0000);
    push(1, 32'h0123_4567, 4'd10, 32'h4B91_A2B3);
    repeat (5) tick();
    @(negedge clk);
    check("stall_accepts", 32'(acc_cnt - a0), 32'd2);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    check("stall_inflight", 32'(inflight), 32'd2);
    check("stall_res_valid", 32'(res_valid), 32'd1);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain("stall", 40);
    check("stall_delivered", 32'(res_cnt - r0), 32'd5);

    // Steady stream: accept and deliver every cycle, occupancy stays at 2
    lat_chk = 1'b1;
    push(0, 32'h0000_0001, 4'd1, 32'h3F80_0000);
    push(0, 32'h0000_0002, 4'd2, 32'h4000_0000);
    push(0, 32'h0000_0003, 4'd3, 32'h4040_0000);
    push(0, 32'h0000_03E8, 4'd4, 32'h447A_0000);
    push(0, 32'hFFFF_FFFF, 4'd5, 32'hBF80_0000);
    push(0, 32'h0000_0000, 4'd6, 32'h0000_0000);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (k >= 2) begin
        check("stream_inflight", 32'(inflight), 32'd2);
        check("stream_accept", 32'(req_ready[0]), 32'd1);
        check("stream_deliver", 32'(res_valid), 32'd1);
      end
    end
    drain("stream", 20);

    // Reset while two operands are in flight
    res_ready = 1'b0;
    push(1, 32'h0000_0003, 4'd11, 32'h4040_0000);
    push(1, 32'h0000_0002, 4'd12, 32'h4000_0000);
    begin
      int w;
      for (w = 0; w < 10; w++) begin
        if (inflight == 2'd2) break;
        tick();
      end
      check("prefill_inflight", 32'(inflight), 32'd2);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_inflight", 32'(inflight), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_res_data", res_data, 32'd0);
    sb.delete();
    vq[1].delete();
    push(0, 32'h0000_03E8, 4'd13, 32'h447A_0000);
    repeat (2) @(negedge clk);
    r0 = res_cnt;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    res_ready = 1'b1;
    drive();
    @(negedge clk);
    check("resume_ready", 32'(req_ready), 32'd1);
    drain("resume", 20);
    repeat (4) tick();
    check("resume_delivered", 32'(res_cnt - r0), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
